// File: rtl/fram_rd_pix_ctrl.sv
// Frame-buffer read side: walks a two-bank line buffer in step with the display
// timing, tracks how many lines are ready, and blanks lines that were not filled.
module fram_rd_pix_ctrl #(
    parameter int          H_ACT     = 1920,
    parameter logic [23:0] BLANK_RGB = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs_in,
    input  logic        hs_in,
    input  logic        de_in,
    input  logic        line_done,
    input  logic [31:0] buf_rd_data,
    output logic [11:0] buf_rd_addr,
    output logic        line_req,
    output logic        line_req_bank,
    output logic        frame_start,
    output logic        vs_out,
    output logic        hs_out,
    output logic        de_out,
    output logic [23:0] pix_data,
    output logic        underflow,
    output logic        overflow
);

    localparam logic [10:0] COL_MAX = 11'(H_ACT - 1);

    logic        vs_d1, hs_d1, de_d1;
    logic        edge_ok;
    logic        bank;
    logic [10:0] col;
    logic [1:0]  avail;
    logic        line_valid;
    logic        prefetch_b1;

    logic vs_rise, de_rise, de_fall, consume;

    // The first cycle after reset has no real previous de_in sample, so a high
    // de_in there is a line already in progress, not a rising edge.
    assign vs_rise = vs_in & ~vs_d1;
    assign de_rise = de_in & ~de_d1 & edge_ok;
    assign de_fall = ~de_in & de_d1;
    assign consume = de_fall & line_valid & (avail != 2'd0);

    assign buf_rd_addr = {bank, col};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d1         <= 1'b0;
            hs_d1         <= 1'b0;
            de_d1         <= 1'b0;
            vs_out        <= 1'b0;
            hs_out        <= 1'b0;
            de_out        <= 1'b0;
            edge_ok       <= 1'b0;
            bank          <= 1'b0;
            col           <= '0;
            avail         <= 2'd0;
            line_valid    <= 1'b0;
            prefetch_b1   <= 1'b0;
            line_req      <= 1'b0;
            line_req_bank <= 1'b0;
            frame_start   <= 1'b0;
            pix_data      <= BLANK_RGB;
            underflow     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            vs_d1       <= vs_in;
            hs_d1       <= hs_in;
            de_d1       <= de_in;
            vs_out      <= vs_d1;
            hs_out      <= hs_d1;
            de_out      <= de_d1;
            edge_ok     <= 1'b1;
            frame_start <= vs_rise;
            line_req    <= 1'b0;
            pix_data    <= (de_d1 && line_valid) ? buf_rd_data[23:0] : BLANK_RGB;

            if (vs_rise) begin
                bank          <= 1'b0;
                col           <= '0;
                avail         <= 2'd0;
                line_valid    <= 1'b0;
                underflow     <= 1'b0;
                overflow      <= 1'b0;
                line_req      <= 1'b1;
                line_req_bank <= 1'b0;
                prefetch_b1   <= 1'b1;
            end else begin
                prefetch_b1 <= 1'b0;

                if (!de_in)
                    col <= '0;
                else if (col != COL_MAX)
                    col <= col + 11'd1;

                // Second half of the frame prefetch wins over a same-cycle line end.
                if (prefetch_b1) begin
                    line_req      <= 1'b1;
                    line_req_bank <= 1'b1;
                end else if (de_fall) begin
                    line_req      <= 1'b1;
                    line_req_bank <= bank;
                end

                if (de_fall)
                    bank <= ~bank;

                if (de_rise) begin
                    line_valid <= (avail != 2'd0);
                    if (avail == 2'd0)
                        underflow <= 1'b1;
                end

                if (line_done && !consume) begin
                    if (avail == 2'd2)
                        overflow <= 1'b1;
                    else
                        avail <= avail + 2'd1;
                end else if (consume && !line_done) begin
                    avail <= avail - 2'd1;
                end
            end
        end
    end

endmodule

// File: doc/fram_rd_pix_ctrl.md
FRAM_RD_PIX_CTRL -- requirements
Module: fram_rd_pix_ctrl

Interface
REQ-001 SHALL have parameter H_ACT, default 1920: active pixels per line, legal range 1..2048.
REQ-002 SHALL have parameter BLANK_RGB, default 24'h000000: pixel value driven on underflow and outside DE.
REQ-003 SHALL have port clk, input, 1 bit: pixel clock; it is the only clock, and rd_clk of the frame read buffer shares it.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port vs_in, input, 1 bit: vsync from the timing generator, active high.
REQ-006 SHALL have port hs_in, input, 1 bit: hsync, active high.
REQ-007 SHALL have port de_in, input, 1 bit: active-video enable.
REQ-008 SHALL have port line_done, input, 1 bit: one-cycle pulse, already synchronised to clk, meaning upstream finished writing one line into the buffer.
REQ-009 SHALL have port buf_rd_data, input, 32 bits: buffer read data, valid 1 cycle after its address.
REQ-010 SHALL have port buf_rd_addr, output, 12 bits: buffer read address {bank, col[10:0]}.
REQ-011 SHALL have port line_req, output, 1 bit: one-cycle pulse requesting upstream to refill a bank.
REQ-012 SHALL have port line_req_bank, output, 1 bit: the bank to refill; valid while line_req=1.
REQ-013 SHALL have port frame_start, output, 1 bit: one-cycle pulse on each vs_in rising edge.
REQ-014 SHALL have ports vs_out, hs_out, de_out, outputs, 1 bit each: the inputs delayed 2 cycles.
REQ-015 SHALL have port pix_data, output, 24 bits: RGB888 pixel aligned with de_out.
REQ-016 SHALL have port underflow, output, 1 bit: sticky flag, cleared at frame_start.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag, cleared at frame_start.

Function
REQ-018 SHALL keep a col counter: 0 whenever de_in=0; +1 each cycle de_in=1; saturates at H_ACT-1.
REQ-019 SHALL drive buf_rd_addr = {bank, col} directly from registers, with no combinational path from de_in.
REQ-020 SHALL register pix_data on the cycle after each address, so the first pixel of a line appears with de_out exactly 2 cycles after de_in rises.
REQ-021 SHALL set pix_data = buf_rd_data[23:0] when the delayed DE is 1 and the current line is valid; otherwise pix_data = BLANK_RGB.
REQ-022 SHALL keep an avail counter (0..2) of lines filled and not yet consumed.
REQ-023 SHALL increment avail on line_done.
REQ-024 SHALL decrement avail on a de_in falling edge (line consumed) only if that line was valid.
REQ-025 SHALL leave avail unchanged when line_done and a consume occur in the same cycle.
REQ-026 SHALL, on line_done while avail=2, keep avail at 2 and set overflow.
REQ-027 SHALL, on a de_in rising edge, mark the line valid if avail>0; if avail=0, mark it invalid, set underflow, and output BLANK_RGB for the whole line.
REQ-028 SHALL, on every de_in falling edge, toggle bank and pulse line_req for one cycle with line_req_bank = the bank just read; this applies to invalid lines too, so the pacing continues.
REQ-029 SHALL, on a vs_in rising edge: pulse frame_start, set bank=0, set col=0, set avail=0, clear both sticky flags, and issue line_req for bank 0 and then for bank 1 on the next cycle (frame prefetch).
REQ-030 SHALL give the vs_in edge priority when a vs_in edge and any other event occur in the same cycle; line_done in that cycle is dropped.
REQ-031 SHALL detect edges using 1-cycle registered copies of vs_in and de_in.

Reset
REQ-032 SHALL, while rst_n=0, immediately force: buf_rd_addr=0, bank=0, col=0, avail=0, line_req=0, line_req_bank=0, frame_start=0, vs_out=hs_out=de_out=0, pix_data=BLANK_RGB, underflow=0, overflow=0, and edge-detect registers=0.
REQ-033 SHALL, when rst_n deasserts mid-line with de_in=1, see no rising edge; that line is treated as invalid until the next de_in rise, with no underflow flag set for the partial line.

Verification
REQ-034 SHALL cover prefetch: vs_in rises -> frame_start=1 for 1 cycle, line_req on bank 0 then bank 1 in consecutive cycles, avail=0.
REQ-035 SHALL cover a normal line: 2 line_done pulses, then de_in high for 1920 cycles with buf_rd_data = address echo -> pix_data[10:0] runs 0..1919 with de_out, 2-cycle latency, then line_req=1 with line_req_bank=0, bank=1, avail=1.
REQ-036 SHALL cover underflow: de_in rises with avail=0 -> underflow=1, pix_data=BLANK_RGB for the whole line, line_req still pulses, avail stays 0.
REQ-037 SHALL cover simultaneous events: line_done in the same cycle as a de_in fall with avail=1 -> avail stays 1; a third line_done with avail=2 -> overflow=1, avail=2.
REQ-038 SHALL cover saturation: H_ACT=4 with de_in high 6 cycles -> col addresses 0,1,2,3,3,3.
REQ-039 SHALL cover reset: rst_n pulled low mid-line -> all outputs at reset values in the same cycle; after release, the next vs_in edge restarts prefetch correctly.
